// File: rtl/axis_fifo_32k_sync.sv
// rtl/axis_fifo_32k_sync.sv - single-clock FWFT AXI4-Stream FIFO, BRAM plus output register
// Optional data_count port enabled by defining AXIS_FIFO_COUNT_EN.
module axis_fifo_32k_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata
`ifdef AXIS_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] data_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_q_valid;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ram_rd;
  logic                  out_load;

  assign wr_en    = s_axis_tvalid & s_axis_tready;
  assign rd_en    = m_axis_tvalid & m_axis_tready;
  assign out_load = ram_q_valid & (~m_axis_tvalid | m_axis_tready);
  // Prefetch whenever the RAM read register is free or is emptying into the output stage.
  // Pointers never alias while data is pending: the pipeline fills long before DEPTH words arrive.
  assign ram_rd   = (wr_ptr != rd_ptr) & (~ram_q_valid | out_load);

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage and read register kept reset-free so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= s_axis_tdata;
    if (ram_rd) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_axis_tready <= 1'b0;
      ram_q_valid   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (ram_rd) rd_ptr <= rd_ptr + AW'(1);
      count         <= count_next;
      s_axis_tready <= (count_next < DEPTH_C);
      if (ram_rd)        ram_q_valid <= 1'b1;
      else if (out_load) ram_q_valid <= 1'b0;
      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q;
      end else if (rd_en) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_FIFO_COUNT_EN
  assign data_count = count;
`endif

endmodule

// File: tb/tb_axis_fifo_32k_sync.sv
// tb/tb_axis_fifo_32k_sync.sv - randomized queue-model bench for axis_fifo_32k_sync
`timescale 1ns/1ps
module tb_axis_fifo_32k_sync;
  localparam int DW    = 16;
  localparam int DEPTH = 32768;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
`ifdef AXIS_FIFO_COUNT_EN
  logic [15:0]   data_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model_q[$];
  logic          wr_hs, rd_hs, exp_ok;
  logic [DW-1:0] rd_data, exp_data;

  axis_fifo_32k_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata)
`ifdef AXIS_FIFO_COUNT_EN
    , .data_count(data_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Samples handshakes mid-cycle, advances one edge, then updates the reference queue.
  task automatic tick();
    @(negedge clk);
    wr_hs    = s_axis_tvalid && s_axis_tready;
    rd_hs    = m_axis_tvalid && m_axis_tready;
    rd_data  = m_axis_tdata;
    exp_ok   = 1'b0;
    exp_data = '0;
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
    end else begin
      if (rd_hs && model_q.size() > 0) begin
        exp_data = model_q.pop_front();
        exp_ok   = 1'b1;
      end
      if (wr_hs) model_q.push_back(s_axis_tdata);
    end
  endtask

  function automatic logic [DW-1:0] stream_word(int i);
    logic signed [DW-1:0] a;
    a = (i / 2 < 50) ? 16'sd8191 : 16'sd2730;
    return (i % 2 == 0) ? -a : a;
  endfunction

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b00 || m_axis_tdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_state: tready=%b tvalid=%b tdata=%h expected 0 0 0000", s_axis_tready, m_axis_tvalid, m_axis_tdata);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: tready=%b tvalid=%b expected 1 0", s_axis_tready, m_axis_tvalid);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_cmp++;
    if (data_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", data_count);
    end
`endif
  endtask

  task automatic test_latency();
    logic [1:0] v;
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'hE001;
    tick();
    s_axis_tvalid = 1'b0;
    v[0] = m_axis_tvalid;
    tick();
    v[1] = m_axis_tvalid;
    tick();
    n_cmp++;
    if (v !== 2'b00 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hE001) begin
      n_err++;
      $display("FAIL latency: tvalid after N,N+1=%b after N+2=%b tdata=%h expected 00 1 e001", v, m_axis_tvalid, m_axis_tdata);
    end
    tick();
    n_cmp++;
    if (!rd_hs || !exp_ok || rd_data !== 16'hE001 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_read: hs=%b data=%h tvalid=%b expected 1 e001 0", rd_hs, rd_data, m_axis_tvalid);
    end
  endtask

  task automatic test_stream();
    int wi = 0, nr = 0, first = -1, last = -1;
    m_axis_tready = 1'b1;
    for (int t = 0; t < 300 && nr < 200; t++) begin
      s_axis_tvalid = (wi < 200);
      s_axis_tdata  = stream_word(wi);
      tick();
      if (wr_hs) wi++;
      if (rd_hs) begin
        n_cmp++;
        if (!exp_ok || rd_data !== exp_data || rd_data !== stream_word(nr)) begin
          n_err++;
          $display("FAIL stream_data[%0d]: got %h expected %h", nr, rd_data, stream_word(nr));
        end
        if (nr == 0) first = t;
        last = t;
        nr++;
      end
    end
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if (nr != 200 || first != 3 || last != 202) begin
      n_err++;
      $display("FAIL stream_timing: reads=%0d first=%0d last=%0d expected 200 3 202", nr, first, last);
    end
  endtask

  task automatic test_full();
    int wi = 0, nr = 0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
    for (int t = 0; t < DEPTH + 100 && wi < DEPTH; t++) begin
      s_axis_tdata = DW'(wi);
      tick();
      if (wr_hs) begin
        wi++;
        if (wi == DEPTH - 1 || wi == DEPTH) begin
          n_cmp++;
          if (s_axis_tready !== (wi != DEPTH)) begin
            n_err++;
            $display("FAIL full_tready at %0d: got %b expected %b", wi, s_axis_tready, (wi != DEPTH));
          end
        end
      end
    end
    n_cmp++;
    if (wi != DEPTH || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0000) begin
      n_err++;
      $display("FAIL full_fill: accepted=%0d tvalid=%b tdata=%h expected %0d 1 0000", wi, m_axis_tvalid, m_axis_tdata, DEPTH);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_cmp++;
    if (data_count !== 16'(DEPTH)) begin
      n_err++;
      $display("FAIL full_count: got %0d expected %0d", data_count, DEPTH);
    end
`endif
    s_axis_tdata = 16'hBEEF; m_axis_tready = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if (!rd_hs || rd_data !== 16'h0000 || wr_hs || s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL full_rw: rd=%b data=%h wr=%b tready=%b expected 1 0000 0 1", rd_hs, rd_data, wr_hs, s_axis_tready);
    end
    nr = 1;
    for (int t = 0; t < DEPTH + 100 && model_q.size() > 0; t++) begin
      tick();
      if (rd_hs) begin
        n_cmp++;
        if (!exp_ok || rd_data !== exp_data || rd_data !== DW'(nr)) begin
          n_err++;
          $display("FAIL drain_data[%0d]: got %h expected %h", nr, rd_data, DW'(nr));
        end
        nr++;
      end
    end
    n_cmp++;
    if (nr != DEPTH || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: reads=%0d tvalid=%b expected %0d 0", nr, m_axis_tvalid, DEPTH);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_cmp++;
    if (data_count !== 16'd0) begin
      n_err++;
      $display("FAIL drain_count: got %0d expected 0", data_count);
    end
`endif
  endtask

  task automatic test_random();
    int wn = 0;
    logic stall;
    logic [DW-1:0] held;
    for (int t = 0; t < 20000 && (wn < 4000 || model_q.size() > 0); t++) begin
      s_axis_tvalid = (wn < 4000) && ($urandom_range(0, 99) < 70);
      s_axis_tdata  = DW'($urandom);
      m_axis_tready = ($urandom_range(0, 99) < 70);
      stall = m_axis_tvalid && !m_axis_tready;
      held  = m_axis_tdata;
      tick();
      if (wr_hs) wn++;
      if (rd_hs) begin
        n_cmp++;
        if (!exp_ok || rd_data !== exp_data) begin
          n_err++;
          $display("FAIL rand_data: got %h expected %h (valid model=%b)", rd_data, exp_data, exp_ok);
        end
      end
      if (stall) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin
          n_err++;
          $display("FAIL rand_stall: tvalid=%b tdata=%h expected 1 %h", m_axis_tvalid, m_axis_tdata, held);
        end
      end
      n_cmp++;
      if (s_axis_tready !== (model_q.size() < DEPTH) || (model_q.size() == 0 && m_axis_tvalid !== 1'b0)) begin
        n_err++;
        $display("FAIL rand_flags: tready=%b tvalid=%b model_words=%0d", s_axis_tready, m_axis_tvalid, model_q.size());
      end
`ifdef AXIS_FIFO_COUNT_EN
      n_cmp++;
      if (data_count !== 16'(model_q.size())) begin
        n_err++;
        $display("FAIL rand_count: got %0d expected %0d", data_count, model_q.size());
      end
`endif
    end
    n_cmp++;
    if (wn != 4000 || model_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_done: written=%0d left=%0d expected 4000 0", wn, model_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int wi = 0, nr = 0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && wi < 100; t++) begin
      s_axis_tdata = DW'($urandom);
      tick();
      if (wr_hs) wi++;
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== 16'h0000) begin
      n_err++;
      $display("FAIL midreset_state: tvalid=%b tready=%b tdata=%h expected 0 0 0000", m_axis_tvalid, s_axis_tready, m_axis_tdata);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_cmp++;
    if (data_count !== 16'd0) begin
      n_err++;
      $display("FAIL midreset_count: got %0d expected 0", data_count);
    end
`endif
    rst = 1'b0; s_axis_tvalid = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    wi = 0;
    for (int t = 0; t < 50 && nr < 5; t++) begin
      s_axis_tvalid = (wi < 5);
      s_axis_tdata  = DW'($urandom);
      tick();
      if (wr_hs) wi++;
      if (rd_hs) begin
        n_cmp++;
        if (!exp_ok || rd_data !== exp_data) begin
          n_err++;
          $display("FAIL midreset_data: got %h expected %h", rd_data, exp_data);
        end
        nr++;
      end
    end
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if (nr != 5) begin
      n_err++;
      $display("FAIL midreset_flow: reads=%0d expected 5", nr);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_full();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
